coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
- Front end of the vending datapath. Drives the 2-bit `coin` code that vending_machine consumes.
- Measures the width of the raw coin-sensor pulse and classifies the coin. Emits a one-cycle coin code, or a reject pulse for bad or inhibited coins.
- Detects jammed sensors and keeps a running count of accepted coins.
- All outputs are registered. Intended to sit directly in front of vending_machine in the top level.

Parameters:
- MIN_W, 4: minimum valid pulse width in cycles. Narrower pulses are rejected.
- SPLIT_W, 8: widths MIN_W..SPLIT_W-1 map to coin 2'b01; widths SPLIT_W..MAX_W map to coin 2'b10.
- MAX_W, 16: maximum valid width. Staying high beyond this is a jam.
- GAP, 3: consecutive low cycles required after a coin before a new pulse is accepted.
- CNT_W, 5: width of the pulse-width counter. Must satisfy 2^CNT_W > MAX_W+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- sense  in  1  raw asynchronous coin sensor; high while a coin passes.
- inhibit  in  1  high = do not accept coins (vending machine busy); sampled at classification.
- coin  out  2  00 none, 01 low-value coin, 10 high-value coin, 11 never driven; non-zero for exactly 1 cycle per accepted coin.
- reject  out  1  1-cycle pulse when a coin is returned.
- jam  out  1  level; high while the sensor is stuck beyond MAX_W.
- busy  out  1  high in any state other than IDLE.
- accepted  out  8  count of accepted coins; wraps 255->0.

Behaviour:
- Reset: synchronous, active-high.
  - Outputs: coin=00, reject=0, jam=0, busy=0, accepted=0.
  - Internals: state=IDLE, synchronizer flops=0, width and gap counters=0.
  - Reset mid-pulse discards the pulse with no coin or reject output. After reset the FSM sits in IDLE; a still-high sense is accepted only after it is seen low first (arm flag cleared by reset, set on the first sense_s=0).
- Input synchronization: sense passes through 2 flops to give sense_s. Pulse widths are measured in sense_s cycles.
- States: IDLE, MEASURE, JAM, GAP.
- IDLE:
  - On sense_s=1 with arm=1: width counter=1, go MEASURE.
- MEASURE:
  - While sense_s=1: width counter increments.
  - When width would exceed MAX_W: assert jam (registered, next cycle) and go JAM.
  - On the first cycle with sense_s=0, classify w = width counter:
    - w<MIN_W: reject.
    - MIN_W<=w<SPLIT_W: code 01.
    - SPLIT_W<=w<=MAX_W: code 10.
    - inhibit=1 in this cycle: any valid code becomes a reject instead.
  - The result is registered: coin or reject is high in the cycle after classification, for 1 cycle. accepted increments in the same cycle that coin is non-zero.
  - Then go GAP.
- JAM:
  - jam held high while sense_s=1.
  - On sense_s=0: jam=0 next cycle, one reject pulse, go GAP. No coin is ever emitted for a jam.
- GAP:
  - Gap counter counts consecutive sense_s=0 cycles. Any sense_s=1 clears the counter; the pulse is ignored with no output.
  - On reaching GAP: go IDLE.
- Latency: raw sense falling sampled at edge k gives coin/reject asserted after edge k+3 (2 synchronizer stages + classify + output register).
- Invariants:
  - coin and reject are never high in the same cycle.
  - coin is never 11.
  - At most one coin/reject per pulse.
- busy: registered decode of state != IDLE.

Test Plan:
- Reset, then a 5-cycle sense pulse, inhibit=0 -> coin=01 for exactly 1 cycle 3 edges after the fall; accepted=1; reject stays 0.
- 10-cycle pulse, then a 16-cycle pulse (each followed by >=3 low cycles) -> coin=10 twice; accepted=2.
- 2-cycle pulse; then a 6-cycle pulse with inhibit=1 -> reject pulses twice; coin stays 00; accepted unchanged.
- 25-cycle pulse -> jam rises after the 17th high sense_s cycle and stays high until the release; then one reject pulse; no coin.
- Second pulse starting 1 cycle after the first coin's release (inside GAP) -> ignored with no output. A pulse after 3 clean low cycles is accepted normally.
- Assert rst for 1 cycle mid-way through a 6-cycle pulse, sense held high -> all outputs 0, no coin. Next valid 5-cycle pulse after sense goes low -> coin=01, accepted=1. 256 accepted coins -> accepted wraps to 0.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes the coin sensor, measures pulse width,
// classifies coins, and reports rejects and sensor jams.
module coin_acceptor #(
    parameter int MIN_W   = 4,
    parameter int SPLIT_W = 8,
    parameter int MAX_W   = 16,
    parameter int GAP     = 3,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense,
    input  logic       inhibit,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic       busy,
    output logic [7:0] accepted
);

    localparam int GAP_CW = (GAP < 2) ? 1 : $clog2(GAP + 1);

    localparam logic [CNT_W-1:0]  MIN_C    = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0]  SPLIT_C  = CNT_W'(SPLIT_W);
    localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_W);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_JAM     = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t state, state_nx;

    logic              sense_m, sense_s;
    logic              sync_v1, sync_v2;
    logic              arm;
    logic [CNT_W-1:0]  width, width_nx;
    logic [GAP_CW-1:0] gap_cnt, gap_nx;
    logic [1:0]        pend_code, pend_code_nx;
    logic              pend_rej, pend_rej_nx;
    logic              jam_nx;

    always_comb begin
        state_nx     = state;
        width_nx     = width;
        gap_nx       = gap_cnt;
        pend_code_nx = 2'b00;
        pend_rej_nx  = 1'b0;
        jam_nx       = 1'b0;
        case (state)
            S_IDLE: begin
                if (sense_s && arm) begin
                    width_nx = CNT_W'(1);
                    state_nx = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (sense_s) begin
                    if (width == MAX_C) begin
                        jam_nx   = 1'b1;
                        state_nx = S_JAM;
                    end else begin
                        width_nx = width + CNT_W'(1);
                    end
                end else begin
                    if (width < MIN_C || inhibit) begin
                        pend_rej_nx = 1'b1;
                    end else if (width < SPLIT_C) begin
                        pend_code_nx = 2'b01;
                    end else begin
                        pend_code_nx = 2'b10;
                    end
                    // the classify cycle already counts as the first quiet cycle
                    gap_nx   = GAP_CW'(1);
                    state_nx = S_GAP;
                end
            end
            S_JAM: begin
                if (sense_s) begin
                    jam_nx = 1'b1;
                end else begin
                    pend_rej_nx = 1'b1;
                    gap_nx      = GAP_CW'(1);
                    state_nx    = S_GAP;
                end
            end
            S_GAP: begin
                if (sense_s) begin
                    gap_nx = '0;
                end else if (gap_cnt >= GAP_LAST) begin
                    gap_nx   = '0;
                    state_nx = S_IDLE;
                end else begin
                    gap_nx = gap_cnt + GAP_CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sense_m   <= 1'b0;
            sense_s   <= 1'b0;
            sync_v1   <= 1'b0;
            sync_v2   <= 1'b0;
            arm       <= 1'b0;
            state     <= S_IDLE;
            width     <= '0;
            gap_cnt   <= '0;
            pend_code <= 2'b00;
            pend_rej  <= 1'b0;
            coin      <= 2'b00;
            reject    <= 1'b0;
            jam       <= 1'b0;
            busy      <= 1'b0;
            accepted  <= 8'd0;
        end else begin
            sense_m <= sense;
            sense_s <= sense_m;
            // sync_v2 marks sense_s as a real sample rather than the reset zero,
            // so a sensor held high through reset cannot arm the acceptor
            sync_v1 <= 1'b1;
            sync_v2 <= sync_v1;
            if (sync_v2 && !sense_s) begin
                arm <= 1'b1;
            end
            state     <= state_nx;
            width     <= width_nx;
            gap_cnt   <= gap_nx;
            pend_code <= pend_code_nx;
            pend_rej  <= pend_rej_nx;
            jam       <= jam_nx;
            busy      <= (state_nx != S_IDLE);
            coin      <= pend_code;
            reject    <= pend_rej;
            if (pend_code != 2'b00) begin
                accepted <= accepted + 8'd1;
            end
        end
    end

endmodule
